// File: rtl/fm_spy_pkg.sv
// Shared definitions for the floating-monitor spy capture/playback engine:
// channel state encodings, playback mode constants and default geometry.
package fm_spy_pkg;

    localparam int DEF_N_CH = 32;
    localparam int DEF_DW   = 64;
    localparam int DEF_AW   = 10;
    localparam int DEF_CW   = 5;

    // Legacy-compatible state constants driven onto the per-channel state port
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_POST     = 3'd2;
    localparam logic [2:0] ST_FROZEN   = 3'd3;
    localparam logic [2:0] ST_PLAYBACK = 3'd4;

    typedef enum logic [2:0] {
        FM_IDLE     = 3'd0,
        FM_ARMED    = 3'd1,
        FM_POST     = 3'd2,
        FM_FROZEN   = 3'd3,
        FM_PLAYBACK = 3'd4
    } fm_spy_state_t;

    localparam logic PB_ONESHOT = 1'b0;
    localparam logic PB_LOOP    = 1'b1;

endpackage

// File: rtl/fm_spy_chan.sv
// One spy channel: capture FSM, circular buffer with a write port and two
// read ports (playback and readout), and the passthrough/playback output mux.
module fm_spy_chan
    import fm_spy_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk_hs,
    input  logic          rst_hs,
    input  logic [DW-1:0] mon_data,
    input  logic          mon_vld,
    input  logic          arm,
    input  logic          force_freeze,
    input  logic          trig,
    input  logic [AW-1:0] post_trig,
    input  logic          pb_start,
    input  logic          pb_loop,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_word,
    output logic [DW-1:0] pb_data,
    output logic          pb_vld,
    output logic [2:0]    state,
    output logic [AW-1:0] wr_ptr,
    output logic          wrapped,
    output logic [AW-1:0] trig_addr
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] pb_ptr;
    logic [AW-1:0] pb_first;
    logic [AW-1:0] pb_last;
    logic          capturing;
    logic          wr_en;
    logic          non_empty;

    always_comb begin
        capturing = (state == ST_ARMED) || (state == ST_POST);
        // arm clears the buffer, so a write coinciding with it is dropped
        wr_en     = capturing && mon_vld && !arm;
        non_empty = (wr_ptr != '0) || wrapped;
        pb_first  = wrapped ? wr_ptr : '0;
        pb_last   = wr_ptr - AW'(1);
    end

    // NOTE: buffer contents are deliberately left out of reset so the array
    // maps onto block RAM; only the control state around it is reset.
    always_ff @(posedge clk_hs) begin
        if (wr_en) begin
            mem[wr_ptr] <= mon_data;
        end
    end

    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            wrapped   <= 1'b0;
            trig_addr <= '0;
            post_cnt  <= '0;
            pb_ptr    <= '0;
            pb_data   <= '0;
            pb_vld    <= 1'b0;
            rd_word   <= '0;
        end else begin
            rd_word <= mem[rd_addr];

            if (state == ST_PLAYBACK) begin
                pb_data <= mem[pb_ptr];
                pb_vld  <= 1'b1;
            end else begin
                pb_data <= mon_data;
                pb_vld  <= mon_vld;
            end

            if (arm) begin
                state    <= ST_ARMED;
                wr_ptr   <= '0;
                wrapped  <= 1'b0;
                post_cnt <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (wr_ptr == '1) begin
                        wrapped <= 1'b1;
                    end
                end

                case (state)
                    ST_ARMED: begin
                        if (force_freeze) begin
                            state <= ST_FROZEN;
                        end else if (trig) begin
                            trig_addr <= wr_ptr;
                            post_cnt  <= post_trig;
                            state     <= (post_trig == '0) ? ST_FROZEN : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (force_freeze) begin
                            state <= ST_FROZEN;
                        end else if (mon_vld) begin
                            post_cnt <= post_cnt - AW'(1);
                            if (post_cnt == AW'(1)) begin
                                state <= ST_FROZEN;
                            end
                        end
                    end
                    ST_FROZEN: begin
                        if (pb_start && non_empty) begin
                            state  <= ST_PLAYBACK;
                            pb_ptr <= pb_first;
                        end
                    end
                    ST_PLAYBACK: begin
                        if (pb_ptr == pb_last) begin
                            if (pb_loop == PB_LOOP) begin
                                pb_ptr <= pb_first;
                            end else begin
                                state <= ST_FROZEN;
                            end
                        end else begin
                            pb_ptr <= pb_ptr + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/fm_spy_ctrl.sv
// Multi-channel spy capture/playback engine: channel array with shared
// trigger and a two-cycle random-access readout port.
module fm_spy_ctrl
    import fm_spy_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int CW   = DEF_CW
) (
    input  logic          clk_hs,
    input  logic          rst_hs,
    input  logic [DW-1:0] mon_data [N_CH],
    input  logic [N_CH-1:0] mon_vld,
    input  logic [N_CH-1:0] arm,
    input  logic [N_CH-1:0] force_freeze,
    input  logic          trig,
    input  logic [AW-1:0] post_trig,
    input  logic [N_CH-1:0] pb_start,
    input  logic [N_CH-1:0] pb_loop,
    output logic [DW-1:0] pb_data [N_CH],
    output logic [N_CH-1:0] pb_vld,
    input  logic          rd_en,
    input  logic [CW-1:0] rd_chan,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    output logic [2:0]    state [N_CH],
    output logic [AW-1:0] wr_ptr [N_CH],
    output logic [N_CH-1:0] wrapped,
    output logic [AW-1:0] trig_addr [N_CH]
);

    logic [DW-1:0] rd_word [N_CH];
    logic [DW-1:0] rd_mux;
    logic [CW-1:0] rd_chan_q;
    logic          rd_en_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        fm_spy_chan #(
            .DW(DW),
            .AW(AW)
        ) u_chan (
            .clk_hs      (clk_hs),
            .rst_hs      (rst_hs),
            .mon_data    (mon_data[g]),
            .mon_vld     (mon_vld[g]),
            .arm         (arm[g]),
            .force_freeze(force_freeze[g]),
            .trig        (trig),
            .post_trig   (post_trig),
            .pb_start    (pb_start[g]),
            .pb_loop     (pb_loop[g]),
            .rd_addr     (rd_addr),
            .rd_word     (rd_word[g]),
            .pb_data     (pb_data[g]),
            .pb_vld      (pb_vld[g]),
            .state       (state[g]),
            .wr_ptr      (wr_ptr[g]),
            .wrapped     (wrapped[g]),
            .trig_addr   (trig_addr[g])
        );
    end

    // A channel select with no matching channel falls through to zero data
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_chan_q == CW'(i)) begin
                rd_mux = rd_word[i];
            end
        end
    end

    always_ff @(posedge clk_hs or posedge rst_hs) begin
        if (rst_hs) begin
            rd_en_q   <= 1'b0;
            rd_chan_q <= '0;
            rd_data   <= '0;
            rd_vld    <= 1'b0;
        end else begin
            rd_en_q   <= rd_en;
            rd_chan_q <= rd_chan;
            rd_vld    <= rd_en_q;
            rd_data   <= rd_en_q ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_fm_spy_ctrl.sv
// Self-checking bench for fm_spy_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural channel/readout model.
module tb_fm_spy_ctrl;
    import fm_spy_pkg::*;

    localparam int N_CH  = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int CW    = 3;
    localparam int DEPTH = 16;

    logic            clk_hs = 1'b0;
    logic            rst_hs;
    logic [DW-1:0]   mon_data [N_CH];
    logic [N_CH-1:0] mon_vld, arm, force_freeze, pb_start, pb_loop;
    logic            trig;
    logic [AW-1:0]   post_trig;
    logic [DW-1:0]   pb_data [N_CH];
    logic [N_CH-1:0] pb_vld, wrapped;
    logic            rd_en;
    logic [CW-1:0]   rd_chan;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_vld;
    logic [2:0]      state [N_CH];
    logic [AW-1:0]   wr_ptr [N_CH];
    logic [AW-1:0]   trig_addr [N_CH];

    // reference model
    int            m_state [N_CH];
    int            m_wp [N_CH];
    int            m_ta [N_CH];
    int            m_cnt [N_CH];
    int            m_pb_idx [N_CH];
    int            m_pb_len [N_CH];
    bit            m_wrap [N_CH];
    bit            m_pbv [N_CH];
    logic [DW-1:0] m_pbd [N_CH];
    logic [DW-1:0] m_mem [N_CH][DEPTH];
    bit            m_rd_v1, m_rd_vld;
    logic [DW-1:0] m_rd_d1, m_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    fm_spy_ctrl #(.N_CH(N_CH), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk_hs      (clk_hs),
        .rst_hs      (rst_hs),
        .mon_data    (mon_data),
        .mon_vld     (mon_vld),
        .arm         (arm),
        .force_freeze(force_freeze),
        .trig        (trig),
        .post_trig   (post_trig),
        .pb_start    (pb_start),
        .pb_loop     (pb_loop),
        .pb_data     (pb_data),
        .pb_vld      (pb_vld),
        .rd_en       (rd_en),
        .rd_chan     (rd_chan),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_vld      (rd_vld),
        .state       (state),
        .wr_ptr      (wr_ptr),
        .wrapped     (wrapped),
        .trig_addr   (trig_addr)
    );

    always #5 clk_hs = ~clk_hs;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_state[c]  = 0;
            m_wp[c]     = 0;
            m_ta[c]     = 0;
            m_cnt[c]    = 0;
            m_pb_idx[c] = 0;
            m_pb_len[c] = 0;
            m_wrap[c]   = 1'b0;
            m_pbv[c]    = 1'b0;
            m_pbd[c]    = '0;
        end
        m_rd_v1   = 1'b0;
        m_rd_vld  = 1'b0;
        m_rd_d1   = '0;
        m_rd_data = '0;
    endtask

    // Advance the model by one clock edge using the inputs presented at it
    task automatic model_edge();
        logic [DW-1:0] nd;
        nd = '0;
        if (rd_en && int'(rd_chan) < N_CH) nd = m_mem[rd_chan][rd_addr];
        m_rd_vld  = m_rd_v1;
        m_rd_data = m_rd_d1;
        m_rd_v1   = rd_en;
        m_rd_d1   = nd;
        for (int c = 0; c < N_CH; c++) begin
            int first;
            int old_wp;
            bit cap;
            first = m_wrap[c] ? m_wp[c] : 0;
            if (m_state[c] == 4) begin
                m_pbv[c] = 1'b1;
                m_pbd[c] = m_mem[c][(first + m_pb_idx[c]) % DEPTH];
            end else begin
                m_pbv[c] = mon_vld[c];
                m_pbd[c] = mon_data[c];
            end
            cap    = (m_state[c] == 1) || (m_state[c] == 2);
            old_wp = m_wp[c];
            if (arm[c]) begin
                m_state[c] = 1;
                m_wp[c]    = 0;
                m_wrap[c]  = 1'b0;
            end else begin
                if (cap && mon_vld[c]) begin
                    m_mem[c][old_wp] = mon_data[c];
                    m_wp[c] = (old_wp + 1) % DEPTH;
                    if (m_wp[c] == 0) m_wrap[c] = 1'b1;
                end
                case (m_state[c])
                    1: begin
                        if (force_freeze[c]) m_state[c] = 3;
                        else if (trig) begin
                            m_ta[c] = old_wp;
                            if (post_trig == 0) m_state[c] = 3;
                            else begin
                                m_state[c] = 2;
                                m_cnt[c]   = int'(post_trig);
                            end
                        end
                    end
                    2: begin
                        if (force_freeze[c]) m_state[c] = 3;
                        else if (mon_vld[c]) begin
                            m_cnt[c]--;
                            if (m_cnt[c] == 0) m_state[c] = 3;
                        end
                    end
                    3: begin
                        if (pb_start[c] && (m_wp[c] != 0 || m_wrap[c])) begin
                            m_state[c]  = 4;
                            m_pb_idx[c] = 0;
                            m_pb_len[c] = m_wrap[c] ? DEPTH : m_wp[c];
                        end
                    end
                    4: begin
                        if (m_pb_idx[c] == m_pb_len[c] - 1) begin
                            if (pb_loop[c]) m_pb_idx[c] = 0;
                            else m_state[c] = 3;
                        end else begin
                            m_pb_idx[c]++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("state[%0d]", c), 64'(state[c]), 64'(m_state[c]));
            check($sformatf("wr_ptr[%0d]", c), 64'(wr_ptr[c]), 64'(m_wp[c]));
            check($sformatf("wrapped[%0d]", c), 64'(wrapped[c]), 64'(m_wrap[c]));
            check($sformatf("trig_addr[%0d]", c), 64'(trig_addr[c]), 64'(m_ta[c]));
            check($sformatf("pb_vld[%0d]", c), 64'(pb_vld[c]), 64'(m_pbv[c]));
            check($sformatf("pb_data[%0d]", c), 64'(pb_data[c]), 64'(m_pbd[c]));
        end
        check("rd_vld", 64'(rd_vld), 64'(m_rd_vld));
        check("rd_data", 64'(rd_data), 64'(m_rd_data));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // then single-cycle pulse inputs are released.
    task automatic tick();
        @(posedge clk_hs);
        model_edge();
        @(negedge clk_hs);
        compare_all();
        arm          = '0;
        force_freeze = '0;
        pb_start     = '0;
        trig         = 1'b0;
        rd_en        = 1'b0;
    endtask

    task automatic write_ch0(input int first_val, input int count);
        for (int k = 0; k < count; k++) begin
            mon_data[0] = DW'(first_val + k);
            mon_vld     = N_CH'(1);
            tick();
        end
        mon_vld = '0;
    endtask

    initial begin
        rst_hs       = 1'b1;
        mon_vld      = '0;
        arm          = '0;
        force_freeze = '0;
        pb_start     = '0;
        pb_loop      = '0;
        trig         = 1'b0;
        post_trig    = '0;
        rd_en        = 1'b0;
        rd_chan      = '0;
        rd_addr      = '0;
        for (int c = 0; c < N_CH; c++) mon_data[c] = '0;
        model_reset();
        @(negedge clk_hs);
        @(negedge clk_hs);
        compare_all();
        rst_hs = 1'b0;

        // Fill every buffer once so later reads never touch unwritten words
        arm = '1;
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < N_CH; c++) mon_data[c] = DW'($urandom);
            mon_vld = '1;
            tick();
        end
        mon_vld = '0;

        // 10 words, no trigger, readout latency
        arm = N_CH'(1);
        tick();
        write_ch0(0, 10);
        check("s1_wr_ptr", 64'(wr_ptr[0]), 64'd10);
        check("s1_wrapped", 64'(wrapped[0]), 64'd0);
        rd_en = 1'b1; rd_chan = '0; rd_addr = AW'(3);
        tick();
        check("s1_rd_vld_early", 64'(rd_vld), 64'd0);
        tick();
        check("s1_rd_vld", 64'(rd_vld), 64'd1);
        check("s1_rd_data", 64'(rd_data), 64'd3);

        // wrap, trigger with post count, one-shot playback
        arm = N_CH'(1);
        tick();
        write_ch0(0, 20);
        trig = 1'b1; post_trig = AW'(3);
        tick();
        write_ch0(20, 3);
        check("s2_state", 64'(state[0]), 64'(FM_FROZEN));
        check("s2_wrapped", 64'(wrapped[0]), 64'd1);
        check("s2_trig_addr", 64'(trig_addr[0]), 64'd4);
        check("s2_wr_ptr", 64'(wr_ptr[0]), 64'd7);
        pb_loop = '0; pb_start = N_CH'(1);
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            check("s2_pb_vld", 64'(pb_vld[0]), 64'd1);
            check("s2_pb_data", 64'(pb_data[0]), 64'(7 + k));
        end
        check("s2_end_state", 64'(state[0]), 64'(FM_FROZEN));
        tick();
        check("s2_end_vld", 64'(pb_vld[0]), 64'd0);

        // post_trig = 0 with a same-cycle write
        arm = N_CH'(1);
        tick();
        write_ch0(16'h50, 2);
        trig = 1'b1; post_trig = '0; mon_data[0] = DW'(16'hAA); mon_vld = N_CH'(1);
        tick();
        check("s3_state", 64'(state[0]), 64'(FM_FROZEN));
        check("s3_wr_ptr", 64'(wr_ptr[0]), 64'd3);
        write_ch0(16'hBB, 2);
        check("s3_wr_ptr_held", 64'(wr_ptr[0]), 64'd3);
        rd_en = 1'b1; rd_chan = '0; rd_addr = AW'(2);
        tick();
        tick();
        check("s3_rd_data", 64'(rd_data), 64'hAA);

        // looped playback of 5 words, aborted by arm
        arm = N_CH'(1);
        tick();
        write_ch0(0, 5);
        force_freeze = N_CH'(1);
        tick();
        check("s4_frozen", 64'(state[0]), 64'(FM_FROZEN));
        pb_loop = N_CH'(1); pb_start = N_CH'(1);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("s4_pb_vld", 64'(pb_vld[0]), 64'd1);
            check("s4_pb_data", 64'(pb_data[0]), 64'(k % 5));
        end
        arm = N_CH'(1);
        tick();
        check("s4_arm_state", 64'(state[0]), 64'(FM_ARMED));
        check("s4_arm_wr_ptr", 64'(wr_ptr[0]), 64'd0);
        mon_data[0] = DW'(16'h1234); mon_vld = N_CH'(1);
        tick();
        mon_vld = '0;
        check("s4_pass_data", 64'(pb_data[0]), 64'h1234);
        check("s4_pass_vld", 64'(pb_vld[0]), 64'd1);

        // priority and empty-buffer playback request
        arm = N_CH'(1); force_freeze = N_CH'(1); trig = 1'b1;
        tick();
        check("s5_state", 64'(state[0]), 64'(FM_ARMED));
        check("s5_wr_ptr", 64'(wr_ptr[0]), 64'd0);
        force_freeze = N_CH'(1);
        tick();
        pb_start = N_CH'(1);
        tick();
        tick();
        check("s5_empty_pb", 64'(state[0]), 64'(FM_FROZEN));

        // asynchronous reset during playback, out-of-range readout channel
        arm = N_CH'(1);
        tick();
        write_ch0(16'h300, 3);
        force_freeze = N_CH'(1);
        tick();
        pb_start = N_CH'(1);
        tick();
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b1; rd_chan = '0; rd_addr = AW'(k);
            tick();
        end
        check("s6_in_playback", 64'(state[0]), 64'(FM_PLAYBACK));
        #2 rst_hs = 1'b1;
        #1 model_reset();
        check("s6_rst_state", 64'(state[0]), 64'(FM_IDLE));
        check("s6_rst_pb_vld", 64'(pb_vld[0]), 64'd0);
        check("s6_rst_pb_data", 64'(pb_data[0]), 64'd0);
        check("s6_rst_rd_vld", 64'(rd_vld), 64'd0);
        compare_all();
        @(negedge clk_hs);
        rst_hs = 1'b0;
        rd_en = 1'b1; rd_chan = CW'(N_CH); rd_addr = AW'(1);
        tick();
        tick();
        check("s6_oor_vld", 64'(rd_vld), 64'd1);
        check("s6_oor_data", 64'(rd_data), 64'd0);

        // randomized traffic on all channels
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                mon_data[c]     = DW'($urandom);
                arm[c]          = ($urandom_range(0, 63) == 0);
                force_freeze[c] = ($urandom_range(0, 127) == 0);
                pb_start[c]     = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 31) == 0) pb_loop[c] = ~pb_loop[c];
            end
            mon_vld   = N_CH'($urandom);
            trig      = ($urandom_range(0, 39) == 0);
            post_trig = AW'($urandom);
            rd_en     = ($urandom_range(0, 1) == 1);
            rd_chan   = CW'($urandom_range(0, 5));
            rd_addr   = AW'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_spy_ctrl.md
Name: fm_spy_ctrl

Overview:
Parametrised multi-channel spy-capture and playback engine for the floating-monitor (FM) path, operating entirely in the clk_hs domain.
- Each channel records its monitored stream into a circular buffer.
- Capture freezes on a global trigger after a programmable number of post-trigger words; a software force-freeze is also available.
- Frozen contents are played back, one-shot or looped, onto the channel output, or read through a shared random-access readout port.
- When a channel is not in playback, its stream passes through with a fixed 1-cycle delay.

Parameters:
N_CH, 32, number of monitored channels
DW, 64, channel data width (bits)
AW, 10, buffer address width; depth = 2**AW words per channel
CW, 5, channel-select width, >= $clog2(N_CH)

Ports:
clk_hs  in  1  system clock
rst_hs  in  1  asynchronous, active-high reset
mon_data  in  DW x N_CH (unpacked)  monitored data per channel
mon_vld  in  N_CH  per-channel data valid
arm  in  N_CH  pulse: clear buffer, start capture
force_freeze  in  N_CH  pulse: immediate freeze
trig  in  1  global trigger pulse
post_trig  in  AW  number of valid words to store after trigger
pb_start  in  N_CH  pulse: start playback
pb_loop  in  N_CH  level: 1 = loop, 0 = one-shot
pb_data  out  DW x N_CH  passthrough/playback data
pb_vld  out  N_CH  output valid
rd_en  in  1  readout request
rd_chan  in  CW  readout channel
rd_addr  in  AW  readout absolute address
rd_data  out  DW  readout data
rd_vld  out  1  readout data valid
state  out  3 x N_CH  channel state encoding
wr_ptr  out  AW x N_CH  next write address
wrapped  out  N_CH  buffer has wrapped since arm
trig_addr  out  AW x N_CH  wr_ptr latched at trigger

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, wrapped=0, trig_addr=0, post counter=0, pb_data=0, pb_vld=0, rd_data=0, rd_vld=0. Reset mid-playback or mid-capture aborts immediately. Memory contents are not reset.
- State encoding: IDLE=0, ARMED=1, POST=2, FROZEN=3, PLAYBACK=4.
- IDLE: no writes.
- arm: taken from any state, including PLAYBACK (aborts it). Next state ARMED; wr_ptr=0, wrapped=0.
- ARMED: each cycle with mon_vld, write mon_data at wr_ptr, then wr_ptr+1 (mod 2**AW). Rolling 2**AW-1 -> 0 sets wrapped (sticky).
- trig in ARMED:
  - trig_addr <= wr_ptr before any same-cycle write.
  - A write in the trigger cycle is stored but not counted.
  - post_trig=0 -> FROZEN next cycle; otherwise -> POST with cnt=post_trig.
  - trig in any other state is ignored.
- POST: each valid write decrements cnt; the write that makes cnt 0 is stored, then -> FROZEN.
- force_freeze: ARMED/POST -> FROZEN; a same-cycle write is stored. Ignored in other states.
- Priority on the same cycle: arm > force_freeze > trig.
- FROZEN: no writes; wr_ptr, wrapped and trig_addr are held.
- pb_start in FROZEN -> PLAYBACK, but only if the buffer is non-empty (wr_ptr!=0 or wrapped); otherwise ignored.
- Playback range: first = wrapped ? wr_ptr : 0; last = wr_ptr-1 (mod). Sequential read of one word per cycle.
- Playback output: pb_data/pb_vld driven 1 cycle after each read, pb_vld=1 for every word.
- Playback end, one-shot: after last, -> FROZEN; pb_vld low from the following cycle.
- Playback end, loop: restart at first with no gap. pb_loop is sampled at each wrap to first.
- Outside PLAYBACK: pb_data <= mon_data, pb_vld <= mon_vld (1-cycle passthrough in every non-playback state).
- Readout:
  - rd_en captures rd_chan/rd_addr; rd_data/rd_vld arrive exactly 2 cycles later; fully pipelined, one request per cycle.
  - rd_chan >= N_CH: rd_vld=1, rd_data=0.
  - Reads are legal in any state. Read-during-write to the same address returns the old data.
- Memory: per channel, one write port and two read ports (playback, readout); inference as two mirrored simple-dual-port RAMs is allowed.

Decomposition:
- Shared package fm_spy_pkg: state enum (fm_spy_state_t), state encodings, mode constants, default N_CH/DW/AW.
- Sub-module fm_spy_chan: per-channel FSM, pointers, post counter, memory, passthrough/playback mux.
- Top fm_spy_ctrl: generate loop over channels, global trigger fan-out, readout channel mux and 2-stage readout pipeline.

Test Plan:
- AW=4, arm ch0, 10 valid words 0..9, no trigger -> wr_ptr=10, wrapped=0; readout addr 3 returns 3 at 2-cycle latency.
- Arm, 20 words 0..19, trig after word 19 with post_trig=3, 3 more words -> FROZEN, wrapped=1, trig_addr=4, wr_ptr=7; one-shot playback outputs 7..22 (16 words), then returns to FROZEN.
- post_trig=0 with trig and mon_vld on the same cycle -> that word stored, FROZEN next cycle, later valid words not written.
- Loop playback of 5 words -> continuous pb_vld pattern 0..4,0..4; an arm pulse mid-stream -> ARMED next cycle with wr_ptr=0, output returns to passthrough.
- arm, force_freeze and trig on the same cycle -> arm wins (ARMED, wr_ptr=0); pb_start on an empty FROZEN buffer -> ignored, state stays FROZEN.
- rst_hs asserted during PLAYBACK -> all outputs 0 and state IDLE asynchronously; rd_chan=N_CH -> rd_data=0, rd_vld=1.
